// File: rtl/if_fetch_queue_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package if_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0001_0000;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_BR,
    REDIR_JAL,
    REDIR_JR
  } redir_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] pc4;
    logic [XLEN_DEF-1:0] instr;
  } entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Memory-request and ID-delivery signals of the fetch front end.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; the source holds valid and payload stable until then and never waits
// on ready to raise valid. Responses carry no ready and are always accepted.
interface if_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc4;
  logic [XLEN-1:0] id_instr;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output id_valid, id_pc, id_pc4, id_instr,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  id_valid, id_pc, id_pc4, id_instr,
    output id_ready
  );
endinterface

// File: rtl/if_fetch_queue_fifo.sv
// Synchronous FIFO with synchronous clear; head reads as zero while empty.
module if_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // At full with a simultaneous pop, wr_q == rd_q: the head is read before the edge overwrites it.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_q] <= push_data;
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem[rd_q] : '0;
  assign occupancy  = count_q;
endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: PC and redirect mux, credit-limited request issue,
// stale-response dropping after redirects, and the instruction queue toward ID.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jal,
  input  logic [XLEN-1:0] jal_target,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_target,
  output logic            flush,
  if_fetch_queue_if.master bus
);
  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

  redir_e          redir_src;
  logic [XLEN-1:0] redir_target;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic            started_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   occupancy;
  logic [CW:0]     credits_used;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic [3*XLEN-1:0] push_data;
  logic [3*XLEN-1:0] head_data;

  always_comb begin
    redir_src    = REDIR_NONE;
    redir_target = pc_q;
    if (jr) begin
      redir_src    = REDIR_JR;
      redir_target = jr_target;
    end else if (jal) begin
      redir_src    = REDIR_JAL;
      redir_target = jal_target;
    end else if (branch_taken) begin
      redir_src    = REDIR_BR;
      redir_target = branch_target;
    end
  end

  assign flush = (redir_src != REDIR_NONE);

  // Queue slots are reserved at request time, so a response always has room.
  assign credits_used       = {1'b0, occupancy} + {1'b0, outstanding_q};
  assign bus.imem_req_valid = started_q && !flush && (credits_used < DEPTH_C);
  assign bus.imem_req_addr  = pc_q;

  assign req_fire         = bus.imem_req_valid && bus.imem_req_ready;
  assign outstanding_next = outstanding_q + CW'(req_fire) - CW'(bus.imem_resp_valid);
  assign push             = bus.imem_resp_valid && !flush && (drop_q == '0);
  assign pop              = bus.id_valid && bus.id_ready && !flush;
  assign push_data        = {resp_pc_q, resp_pc_q + FOUR, bus.imem_resp_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      started_q     <= 1'b0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      started_q     <= 1'b1;
      outstanding_q <= outstanding_next;
      if (flush) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc_q      <= redir_target;
        resp_pc_q <= redir_target;
        drop_q    <= outstanding_next;
      end else begin
        if (req_fire) pc_q <= pc_q + FOUR;
        if (bus.imem_resp_valid) begin
          if (drop_q != '0) drop_q    <= drop_q - CW'(1);
          else              resp_pc_q <= resp_pc_q + FOUR;
        end
      end
    end
  end

  if_fifo #(
    .WIDTH (3*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (flush),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_valid (bus.id_valid),
    .head_data  (head_data),
    .occupancy  (occupancy)
  );

  assign bus.id_pc    = head_data[3*XLEN-1 -: XLEN];
  assign bus.id_pc4   = head_data[2*XLEN-1 -: XLEN];
  assign bus.id_instr = head_data[XLEN-1:0];
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: in-order memory model with random latency/ready,
// and a scoreboard of correct-path fetch addresses checked at every ID pop.
module tb_if_fetch_queue;
  import if_pkg::*;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0001_0000;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            branch_taken, jal, jr, flush;
  logic [XLEN-1:0] branch_target, jal_target, jr_target;

  if_fetch_queue_if #(.XLEN(XLEN)) bus ();

  if_fetch_queue #(
    .XLEN (XLEN), .RESET_PC (RPC), .DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jal           (jal),
    .jal_target    (jal_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .flush         (flush),
    .bus           (bus)
  );

  always #5 clock = ~clock;

  // scoreboard and memory model
  int              tests = 0;
  int              fails = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] mem_q[$];
  int              mem_due[$];
  logic [XLEN-1:0] exp_req;
  int              cycle = 0;
  int              req_count, resp_count, pop_count;

  // stimulus knobs and one-shot forced redirect
  int              rdy_pct, idr_pct, lat_min, lat_max, redir_pct;
  logic            use_force, f_br, f_jal, f_jr;
  logic [XLEN-1:0] f_br_t, f_jal_t, f_jr_t;

  logic            s_req_valid, s_id_valid, s_flush;
  logic [XLEN-1:0] s_req_addr, s_id_pc, s_id_pc4;

  function automatic logic [XLEN-1:0] hash(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [XLEN-1:0] rand_target();
    logic [XLEN-1:0] t;
    t = {$urandom(), 2'b00};
    if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0 | {28'd0, $urandom_range(3), 2'b00};
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.imem_req_ready  = 1'b0;
    bus.id_ready        = 1'b0;
    branch_taken = 1'b0; jal = 1'b0; jr = 1'b1;
    mem_q.delete(); mem_due.delete(); exp_q.delete();
    exp_req = RPC; req_count = 0; resp_count = 0; pop_count = 0;
    #1;
    check("rst_id_valid", bus.id_valid, 1'b0);
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_req_addr", bus.imem_req_addr, RPC);
    check("rst_id_pc", bus.id_pc, 0);
    check("rst_id_pc4", bus.id_pc4, 0);
    check("rst_id_instr", bus.id_instr, 0);
    check("rst_flush_follows", flush, 1'b1);
    jr = 1'b0;
    #1;
    check("rst_flush_low", flush, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // One clock cycle: drive at posedge+1, check and update the model at negedge.
  task automatic step();
    int              lat, due;
    logic [XLEN-1:0] tgt;
    logic            fire, pop;
    entry_t          e;
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    bus.id_ready       = ($urandom_range(99) < idr_pct);
    branch_target = rand_target(); jal_target = rand_target(); jr_target = rand_target();
    if (use_force) begin
      branch_taken = f_br; jal = f_jal; jr = f_jr;
      branch_target = f_br_t; jal_target = f_jal_t; jr_target = f_jr_t;
      use_force = 1'b0;
    end else if ($urandom_range(99) < redir_pct) begin
      branch_taken = $urandom_range(1); jal = $urandom_range(1); jr = $urandom_range(1);
      if (!(branch_taken || jal || jr)) branch_taken = 1'b1;
    end else begin
      branch_taken = 1'b0; jal = 1'b0; jr = 1'b0;
    end
    if (mem_q.size() != 0 && mem_due[0] <= cycle) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = hash(mem_q[0]);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom();
    end

    @(negedge clock);
    s_req_valid = bus.imem_req_valid; s_req_addr = bus.imem_req_addr;
    s_id_valid  = bus.id_valid; s_id_pc = bus.id_pc; s_id_pc4 = bus.id_pc4;
    s_flush     = flush;
    check("flush", flush, branch_taken | jal | jr);
    tgt = jr ? jr_target : (jal ? jal_target : branch_target);
    if (flush) check("req_during_redirect", s_req_valid, 1'b0);
    if (s_req_valid) check("req_addr", s_req_addr, exp_req);
    fire = bus.imem_req_valid && bus.imem_req_ready;
    pop  = bus.id_valid && bus.id_ready && !flush;
    if (pop) begin
      check("pop_has_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e.pc = exp_q.pop_front(); e.pc4 = e.pc + 32'd4; e.instr = hash(e.pc);
        check("id_pc", bus.id_pc, e.pc);
        check("id_pc4", bus.id_pc4, e.pc4);
        check("id_instr", bus.id_instr, e.instr);
      end
      pop_count++;
    end
    if (bus.imem_resp_valid) begin
      void'(mem_q.pop_front());
      void'(mem_due.pop_front());
      resp_count++;
    end
    if (flush) begin
      exp_q.delete();
      exp_req = tgt;
    end else if (fire) begin
      exp_q.push_back(exp_req);
      mem_q.push_back(exp_req);
      lat = $urandom_range(lat_max, lat_min);
      due = cycle + lat;
      if (mem_due.size() != 0 && due < mem_due[mem_due.size()-1]) due = mem_due[mem_due.size()-1];
      mem_due.push_back(due);
      exp_req = exp_req + 32'd4;
      req_count++;
    end
    check("outstanding_bound", mem_q.size() <= DEPTH, 1'b1);
    @(posedge clock);
    #1;
    cycle++;
  endtask

  task automatic force_redirect(input logic br, input logic [XLEN-1:0] brt,
                                input logic j, input logic [XLEN-1:0] jt,
                                input logic r, input logic [XLEN-1:0] rt);
    use_force = 1'b1;
    f_br = br; f_br_t = brt; f_jal = j; f_jal_t = jt; f_jr = r; f_jr_t = rt;
  endtask

  initial begin
    int n;
    use_force = 1'b0;
    branch_taken = 1'b0; jal = 1'b0; jr = 1'b0;
    branch_target = '0; jal_target = '0; jr_target = '0;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0; bus.id_ready = 1'b0;
    rdy_pct = 100; idr_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
    @(posedge clock);
    #1;

    // sequential stream after reset, 1-cycle memory
    do_reset();
    n = 0;
    step();
    while (!s_req_valid && n < 5) begin step(); n++; end
    check("t1_req_rise", s_req_valid, 1'b1);
    check("t1_first_addr", s_req_addr, RPC);
    step();
    check("t1_idv_not_yet", s_id_valid, 1'b0);
    step();
    check("t1_idv", s_id_valid, 1'b1);
    check("t1_id_pc", s_id_pc, RPC);
    repeat (20) step();
    check("t1_throughput", pop_count >= 20, 1'b1);

    // ID stalled: credits stop issue at DEPTH
    do_reset();
    idr_pct = 0;
    repeat (20) step();
    check("t2_req_count", req_count, DEPTH);
    check("t2_req_stopped", s_req_valid, 1'b0);
    check("t2_head_valid", s_id_valid, 1'b1);
    check("t2_head_pc", s_id_pc, RPC);
    idr_pct = 100;
    repeat (3) step();
    check("t2_resume", req_count > DEPTH, 1'b1);

    // branch with two requests outstanding
    do_reset();
    lat_min = 3; lat_max = 3;
    n = 0;
    while (mem_q.size() != 2 && n < 10) begin step(); n++; end
    check("t3_two_outstanding", mem_q.size(), 2);
    force_redirect(1'b1, 32'h0002_0000, 1'b0, '0, 1'b0, '0);
    step();
    check("t3_flush", s_flush, 1'b1);
    step();
    check("t3_queue_empty", s_id_valid, 1'b0);
    n = 0;
    while (!s_id_valid && n < 20) begin step(); n++; end
    check("t3_idv_after", s_id_valid, 1'b1);
    check("t3_id_pc", s_id_pc, 32'h0002_0000);

    // jr wins over branch in the same cycle
    lat_min = 1; lat_max = 1;
    force_redirect(1'b1, 32'h0002_0000, 1'b0, '0, 1'b1, 32'h0003_0000);
    step();
    check("t4_flush", s_flush, 1'b1);
    step();
    check("t4_req_valid", s_req_valid, 1'b1);
    check("t4_req_addr", s_req_addr, 32'h0003_0000);

    // PC wrap at the top of the address space
    force_redirect(1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0);
    step();
    step();
    check("t5_req_top", s_req_addr, 32'hFFFF_FFFC);
    step();
    check("t5_req_wrap_valid", s_req_valid, 1'b1);
    check("t5_req_wrap", s_req_addr, 32'h0000_0000);
    n = 0;
    while (!(s_id_valid && s_id_pc == 32'hFFFF_FFFC) && n < 10) begin step(); n++; end
    check("t5_head_pc", s_id_pc, 32'hFFFF_FFFC);
    check("t5_head_pc4", s_id_pc4, 32'h0000_0000);

    // reset mid-stream with three entries queued
    do_reset();
    idr_pct = 0;
    n = 0;
    while (resp_count != 3 && n < 20) begin step(); n++; end
    check("t6_three_resp", resp_count, 3);
    check("t6_queued", bus.id_valid, 1'b1);
    do_reset();
    idr_pct = 100;
    n = 0;
    step();
    while (!s_req_valid && n < 5) begin step(); n++; end
    check("t6_req_valid", s_req_valid, 1'b1);
    check("t6_req_addr", s_req_addr, RPC);

    // randomized traffic
    do_reset();
    rdy_pct = 70; idr_pct = 60; lat_min = 1; lat_max = 4; redir_pct = 4;
    repeat (3000) step();
    check("rand_progress", pop_count > 200, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
